tdpu_dot_accum: RTL

Pipelined, parametrised ternary dot-product engine for the TDPU datapath. Each beat carries LEN signed activations and LEN ternary weights (package_def weight_t: W_POS/W_NEG/W_ZERO). Partial sums are reduced through a registered adder tree and accumulated across a variable number of beats into one result. A valid/ready stream on both sides allows long vectors (K = beats × LEN) to be streamed from the activation/weight buffers to the output writeback stage.

---
 rtl/tdpu_dot_accum.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/tdpu_dot_accum.sv
// tdpu_dot_accum: pipelined ternary dot-product engine.
// Lane products -> registered sum -> accumulate across beats.

package package_def;
   typedef enum logic [1:0] {
      W_ZERO = 2'b00,
      W_POS  = 2'b01,
      W_NEG  = 2'b10
   } weight_t;
endpackage

module tdpu_dot_accum
   import package_def::*;
#(
   parameter int LEN      = 16,
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 32,
   parameter bit SATURATE = 1'b1
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_valid,
   output logic                           o_ready,
   input  logic [LEN-1:0][DATA_W-1:0]     i_data,
   input  weight_t [LEN-1:0]              i_weight,
   input  logic                           i_last,
   output logic                           o_valid,
   input  logic                           i_ready,
   output logic signed [ACC_W-1:0]        o_result,
   output logic                           o_overflow
);
   localparam int PROD_W = DATA_W + 1;
   localparam int SUM_W  = DATA_W + $clog2(LEN) + 1;
   localparam int T_W    = ACC_W + 1;

   localparam logic signed [ACC_W-1:0] ACC_MAX =
      {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN =
      {1'b1, {(ACC_W-1){1'b0}}};

   logic                       en;
   logic [LEN-1:0][PROD_W-1:0] prod_d;
   logic [LEN-1:0][PROD_W-1:0] s1_prod;
   logic                       s1_valid;
   logic                       s1_last;
   logic signed [SUM_W-1:0]    sum_d;
   logic signed [SUM_W-1:0]    s2_sum;
   logic                       s2_valid;
   logic                       s2_last;
   logic signed [ACC_W-1:0]    acc;
   logic signed [ACC_W-1:0]    base;
   logic signed [ACC_W-1:0]    value;
   logic signed [T_W-1:0]      t;
   logic                       first;
   logic                       ovf_acc;
   logic                       ovf_step;

   // A held result freezes every stage at once.
   assign en      = !(o_valid && !i_ready);
   assign o_ready = en;

   // One extra bit lets -(-2^(DATA_W-1)) stay positive.
   always_comb begin
      prod_d = '0;
      for (int i = 0; i < LEN; i++) begin
         unique case (i_weight[i])
            W_POS:   prod_d[i] = PROD_W'($signed(i_data[i]));
            W_NEG:   prod_d[i] = -PROD_W'($signed(i_data[i]));
            default: prod_d[i] = '0;
         endcase
      end
   end

   // Lane stage: products only load on an accepted beat.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_prod  <= '0;
      end else if (en) begin
         s1_valid <= i_valid;
         s1_last  <= i_last;
         if (i_valid)
            s1_prod <= prod_d;
      end
   end

   // Reduce all lane products; width covers the worst-case sum.
   always_comb begin
      sum_d = '0;
      for (int i = 0; i < LEN; i++)
         sum_d = sum_d + SUM_W'($signed(s1_prod[i]));
   end

   // Tree stage: register the reduced beat sum.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         s2_sum   <= '0;
      end else if (en) begin
         s2_valid <= s1_valid;
         s2_last  <= s1_last;
         if (s1_valid)
            s2_sum <= sum_d;
      end
   end

   // Full-precision add, then clamp or wrap back to ACC_W bits.
   always_comb begin
      base     = first ? '0 : acc;
      t        = T_W'(base) + T_W'(s2_sum);
      ovf_step = t[T_W-1] != t[T_W-2];
      value    = t[ACC_W-1:0];
      if (SATURATE && ovf_step)
         value = t[T_W-1] ? ACC_MIN : ACC_MAX;
   end

   // Accumulate stage: fold beats, publish on the last one.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         acc        <= '0;
         first      <= 1'b1;
         ovf_acc    <= 1'b0;
         o_valid    <= 1'b0;
         o_result   <= '0;
         o_overflow <= 1'b0;
      end else if (en) begin
         o_valid <= 1'b0;
         if (s2_valid) begin
            if (s2_last) begin
               o_valid    <= 1'b1;
               o_result   <= value;
               o_overflow <= ovf_acc | ovf_step;
               acc        <= '0;
               first      <= 1'b1;
               ovf_acc    <= 1'b0;
            end else begin
               acc     <= value;
               first   <= 1'b0;
               ovf_acc <= ovf_acc | ovf_step;
            end
         end
      end
   end

endmodule
